// File: rtl/video_timing_generator_pkg.sv
// Default timing for a 64x256 cell display and the legality check used at elaboration.
// Constants and functions only; no logic.
package video_timing_pkg;

  localparam int unsigned DEF_DOT_DIV  = 4;
  localparam int unsigned DEF_H_TOTAL  = 80;
  localparam int unsigned DEF_H_ACTIVE = 64;
  localparam int unsigned DEF_HS_START = 68;
  localparam int unsigned DEF_HS_WIDTH = 6;
  localparam int unsigned DEF_V_TOTAL  = 312;
  localparam int unsigned DEF_V_ACTIVE = 256;
  localparam int unsigned DEF_VS_START = 272;
  localparam int unsigned DEF_VS_WIDTH = 4;
  localparam int unsigned DEF_ADDR_W   = 15;

  // Counter width that never collapses to zero bits for a modulus of 1.
  function automatic int unsigned cnt_w(input int unsigned modulus);
    return (modulus > 1) ? $clog2(modulus) : 1;
  endfunction

  function automatic bit timing_params_ok(
    input int unsigned dot_div,
    input int unsigned h_total, input int unsigned h_active,
    input int unsigned hs_start, input int unsigned hs_width,
    input int unsigned v_total, input int unsigned v_active,
    input int unsigned vs_start, input int unsigned vs_width,
    input int unsigned addr_w
  );
    longint unsigned cap;
    longint unsigned cells;
    cells = 64'(h_active) * 64'(v_active);
    cap   = (addr_w >= 64) ? '1 : (64'(1) << addr_w);
    return (dot_div >= 3) &&
           (hs_start + hs_width <= h_total) &&
           (vs_start + vs_width <= v_total) &&
           (h_active <= h_total) &&
           (v_active <= v_total) &&
           (cap >= cells);
  endfunction

endpackage

// File: rtl/video_timing_generator_if.sv
// Control inputs and timing/strobe outputs of the video timing generator.
// Pure wiring; master is the generator, slave is the consumer.
interface video_timing_generator_if #(
  parameter int unsigned ADDR_W = 15
);
  logic              enable;
  logic              int_ack;
  logic              cpu_clock_en;
  logic              ras_al;
  logic              cas_al;
  logic              ld_sft_al;
  logic              hsync_al;
  logic              vsync_al;
  logic              blank_al;
  logic              int_al;
  logic [ADDR_W-1:0] av;

  modport master (
    input  enable, int_ack,
    output cpu_clock_en, ras_al, cas_al, ld_sft_al,
    output hsync_al, vsync_al, blank_al, int_al, av
  );

  modport slave (
    output enable, int_ack,
    input  cpu_clock_en, ras_al, cas_al, ld_sft_al,
    input  hsync_al, vsync_al, blank_al, int_al, av
  );
endinterface

// File: rtl/video_timing_counter.sv
// Modulo-MODULUS counter stepping while inc is high; exposes its next value and a wrap flag.
// Next value is combinational so callers can register decodes on the same edge as the count.
module video_timing_counter
  import video_timing_pkg::*;
#(
  parameter int unsigned MODULUS = 4,
  parameter int unsigned W       = cnt_w(MODULUS)
) (
  input  logic         clock_10mhz,
  input  logic         reset_al,
  input  logic         inc,
  output logic [W-1:0] count_nxt,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MODULUS - 1);

  logic [W-1:0] count;

  assign wrap = inc && (count == LAST);

  always_comb begin
    count_nxt = count;
    if (inc) count_nxt = (count == LAST) ? '0 : count + W'(1);
  end

  always_ff @(posedge clock_10mhz or negedge reset_al) begin
    if (!reset_al) count <= '0;
    else           count <= count_nxt;
  end

endmodule

// File: rtl/video_timing_generator.sv
// Character-cell video timing: phase/cell/line counters, DRAM and shifter strobes, syncs, AV, frame IRQ.
// Outputs registered from next-state decode (zero added latency); no backpressure, ENABLE freezes.
module video_timing_generator
  import video_timing_pkg::*;
#(
  parameter int unsigned DOT_DIV  = DEF_DOT_DIV,
  parameter int unsigned H_TOTAL  = DEF_H_TOTAL,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned HS_START = DEF_HS_START,
  parameter int unsigned HS_WIDTH = DEF_HS_WIDTH,
  parameter int unsigned V_TOTAL  = DEF_V_TOTAL,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned VS_START = DEF_VS_START,
  parameter int unsigned VS_WIDTH = DEF_VS_WIDTH,
  parameter int unsigned ADDR_W   = DEF_ADDR_W
) (
  input logic                       clock_10mhz,
  input logic                       reset_al,
  video_timing_generator_if.master  bus
);

  localparam int unsigned PH_W = cnt_w(DOT_DIV);
  localparam int unsigned H_W  = cnt_w(H_TOTAL);
  localparam int unsigned V_W  = cnt_w(V_TOTAL);

  if (!timing_params_ok(DOT_DIV, H_TOTAL, H_ACTIVE, HS_START, HS_WIDTH,
                        V_TOTAL, V_ACTIVE, VS_START, VS_WIDTH, ADDR_W)) begin : g_bad_params
    $error("video_timing_generator: illegal timing parameters");
  end

  logic [PH_W-1:0]   ph_nxt;
  logic [H_W-1:0]    h_nxt;
  logic [V_W-1:0]    v_nxt;
  logic              ph_wrap, h_wrap, v_wrap;
  logic              cpu_nxt, ras_nxt, cas_nxt, ld_nxt;
  logic              hs_nxt, vs_nxt, blank_nxt, int_set;
  logic [ADDR_W-1:0] av_nxt;

  logic              cpu_q, ras_q, cas_q, ld_q;
  logic              hs_q, vs_q, blank_q, int_q;
  logic [ADDR_W-1:0] av_q;

  video_timing_counter #(.MODULUS(DOT_DIV), .W(PH_W)) u_phase (
    .clock_10mhz (clock_10mhz), .reset_al (reset_al), .inc (bus.enable),
    .count_nxt   (ph_nxt),      .wrap     (ph_wrap)
  );

  video_timing_counter #(.MODULUS(H_TOTAL), .W(H_W)) u_h (
    .clock_10mhz (clock_10mhz), .reset_al (reset_al), .inc (ph_wrap),
    .count_nxt   (h_nxt),       .wrap     (h_wrap)
  );

  video_timing_counter #(.MODULUS(V_TOTAL), .W(V_W)) u_v (
    .clock_10mhz (clock_10mhz), .reset_al (reset_al), .inc (h_wrap),
    .count_nxt   (v_nxt),       .wrap     (v_wrap)
  );

  always_comb begin
    cpu_nxt   = bus.enable && (32'(ph_nxt) == DOT_DIV - 1);
    ras_nxt   = !(bus.enable && (ph_nxt != '0));
    cas_nxt   = !(bus.enable && (32'(ph_nxt) >= 2));
    ld_nxt    = !(cpu_nxt && (32'(h_nxt) < H_ACTIVE) && (32'(v_nxt) < V_ACTIVE));
    hs_nxt    = !((32'(h_nxt) >= HS_START) && (32'(h_nxt) < HS_START + HS_WIDTH));
    vs_nxt    = !((32'(v_nxt) >= VS_START) && (32'(v_nxt) < VS_START + VS_WIDTH));
    blank_nxt = !((32'(h_nxt) >= H_ACTIVE) || (32'(v_nxt) >= V_ACTIVE));
    int_set   = h_wrap && (32'(v_nxt) == V_ACTIVE);
    // blank_q already decodes the current cell, so it doubles as "leaving an active cell".
    av_nxt    = av_q;
    if (v_wrap)                av_nxt = '0;
    else if (ph_wrap && blank_q) av_nxt = av_q + ADDR_W'(1);
  end

  always_ff @(posedge clock_10mhz or negedge reset_al) begin
    if (!reset_al) begin
      cpu_q   <= 1'b0;
      ras_q   <= 1'b1;
      cas_q   <= 1'b1;
      ld_q    <= 1'b1;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b1;
      int_q   <= 1'b1;
      av_q    <= '0;
    end else begin
      cpu_q <= cpu_nxt;
      ras_q <= ras_nxt;
      cas_q <= cas_nxt;
      ld_q  <= ld_nxt;
      av_q  <= av_nxt;
      if (bus.enable) begin
        hs_q    <= hs_nxt;
        vs_q    <= vs_nxt;
        blank_q <= blank_nxt;
        if (int_set)          int_q <= 1'b0;
        else if (bus.int_ack) int_q <= 1'b1;
      end
    end
  end

  assign bus.cpu_clock_en = cpu_q;
  assign bus.ras_al       = ras_q;
  assign bus.cas_al       = cas_q;
  assign bus.ld_sft_al    = ld_q;
  assign bus.hsync_al     = hs_q;
  assign bus.vsync_al     = vs_q;
  assign bus.blank_al     = blank_q;
  assign bus.int_al       = int_q;
  assign bus.av           = av_q;

endmodule

// File: tb/tb_video_timing_generator.sv
// Scoreboard bench: dut0 runs the default timing, dut1 a tiny frame for wrap and IRQ-coincidence cases.
module tb_video_timing_generator;

  localparam int S_CPU = 0, S_RAS = 1, S_CAS = 2, S_LD = 3, S_HS = 4;
  localparam int S_VS = 5, S_BL = 6, S_AV = 7, S_INT = 8;

  typedef struct {
    int unsigned at;
    int          sig;
    logic [31:0] val;
    string       nm;
  } exp_t;

  logic        clk;
  logic        rst0, rst1;
  int unsigned edge_n = 0;
  bit          draining = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        sb0[$];
  exp_t        sb1[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) edge_n++;

  video_timing_generator_if #(.ADDR_W(15)) bus0 ();
  video_timing_generator_if #(.ADDR_W(5))  bus1 ();

  video_timing_generator u_dut0 (
    .clock_10mhz (clk),
    .reset_al    (rst0),
    .bus         (bus0)
  );

  video_timing_generator #(
    .DOT_DIV (3), .H_TOTAL (8), .H_ACTIVE (5), .HS_START (6), .HS_WIDTH (2),
    .V_TOTAL (6), .V_ACTIVE (4), .VS_START (4), .VS_WIDTH (1), .ADDR_W (5)
  ) u_dut1 (
    .clock_10mhz (clk),
    .reset_al    (rst1),
    .bus         (bus1)
  );

  function automatic logic [31:0] sample(input int d, input int s);
    logic [31:0] r;
    r = '1;
    case (s)
      S_CPU: r = (d == 0) ? 32'(bus0.cpu_clock_en) : 32'(bus1.cpu_clock_en);
      S_RAS: r = (d == 0) ? 32'(bus0.ras_al)       : 32'(bus1.ras_al);
      S_CAS: r = (d == 0) ? 32'(bus0.cas_al)       : 32'(bus1.cas_al);
      S_LD:  r = (d == 0) ? 32'(bus0.ld_sft_al)    : 32'(bus1.ld_sft_al);
      S_HS:  r = (d == 0) ? 32'(bus0.hsync_al)     : 32'(bus1.hsync_al);
      S_VS:  r = (d == 0) ? 32'(bus0.vsync_al)     : 32'(bus1.vsync_al);
      S_BL:  r = (d == 0) ? 32'(bus0.blank_al)     : 32'(bus1.blank_al);
      S_AV:  r = (d == 0) ? 32'(bus0.av)           : 32'(bus1.av);
      S_INT: r = (d == 0) ? 32'(bus0.int_al)       : 32'(bus1.int_al);
      default: r = '1;
    endcase
    return r;
  endfunction

  task automatic push(input int d, input int unsigned at, input int s,
                      input logic [31:0] v, input string nm);
    exp_t e;
    e.at = at; e.sig = s; e.val = v; e.nm = nm;
    if (d == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endtask

  task automatic push_reset(input int d, input int unsigned at, input string nm);
    push(d, at, S_CPU, 0, {nm, "_cpu"});
    push(d, at, S_RAS, 1, {nm, "_ras"});
    push(d, at, S_CAS, 1, {nm, "_cas"});
    push(d, at, S_LD,  1, {nm, "_ld"});
    push(d, at, S_HS,  1, {nm, "_hs"});
    push(d, at, S_VS,  1, {nm, "_vs"});
    push(d, at, S_BL,  1, {nm, "_blank"});
    push(d, at, S_AV,  0, {nm, "_av"});
    push(d, at, S_INT, 1, {nm, "_int"});
  endtask

  task automatic judge(input int d, input exp_t e);
    logic [31:0] act;
    checks++;
    if (e.at != edge_n) begin
      errors++;
      $display("FAIL %s dut%0d: expected at edge %0d but not checked in time (now edge %0d)",
               e.nm, d, e.at, edge_n);
    end else begin
      act = sample(d, e.sig);
      if (act !== e.val) begin
        errors++;
        $display("FAIL %s dut%0d edge %0d: got %0d, want %0d", e.nm, d, e.at, act, e.val);
      end
    end
  endtask

  // Monitor: compare every expectation due at this edge, sampled on the falling edge.
  always @(negedge clk) begin
    while (sb0.size() > 0 && (draining || sb0[0].at <= edge_n)) judge(0, sb0.pop_front());
    while (sb1.size() > 0 && (draining || sb1[0].at <= edge_n)) judge(1, sb1.pop_front());
  end

  task automatic wait_until(input int unsigned e);
    while (edge_n < e) @(negedge clk);
  endtask

  task automatic seq_default();
    int unsigned b, b2;
    logic [3:0]  cpu_pat, ras_pat, cas_pat;
    cpu_pat = 4'b1000;
    ras_pat = 4'b0001;
    cas_pat = 4'b0011;
    rst0 = 1'b0; bus0.enable = 1'b1; bus0.int_ack = 1'b0;
    push_reset(0, 2, "reset_hold");
    wait_until(3);
    rst0 = 1'b1;
    b = edge_n;

    for (int k = 1; k <= 12; k++) begin
      push(0, b + k, S_CPU, {31'b0, cpu_pat[k % 4]}, "cpu_en_phase");
      push(0, b + k, S_RAS, {31'b0, ras_pat[k % 4]}, "ras_phase");
      push(0, b + k, S_CAS, {31'b0, cas_pat[k % 4]}, "cas_phase");
      push(0, b + k, S_LD,  {31'b0, !cpu_pat[k % 4]}, "ld_phase");
      if (k % 4 == 0) push(0, b + k, S_AV, k / 4, "av_step");
    end

    push(0, b + 255, S_BL, 1, "blank_before");
    push(0, b + 256, S_BL, 0, "blank_start");
    push(0, b + 256, S_AV, 64, "av_hold_blank");
    push(0, b + 259, S_LD, 1, "ld_in_blank");
    push(0, b + 271, S_HS, 1, "hsync_before");
    push(0, b + 272, S_HS, 0, "hsync_start");
    push(0, b + 295, S_HS, 0, "hsync_last");
    push(0, b + 296, S_HS, 1, "hsync_end");
    push(0, b + 319, S_BL, 0, "blank_last");
    push(0, b + 320, S_BL, 1, "blank_end");
    push(0, b + 320, S_AV, 64, "av_line1");
    push(0, b + 591, S_HS, 1, "hsync2_before");
    push(0, b + 592, S_HS, 0, "hsync2_start");
    push(0, b + 81852, S_AV, 16383, "av_last_cell");
    push(0, b + 81855, S_LD, 0, "ld_last_cell");
    push(0, b + 81859, S_LD, 1, "ld_after_active");
    push(0, b + 81919, S_INT, 1, "int_before");
    push(0, b + 81920, S_INT, 0, "int_fall");
    push(0, b + 81920, S_BL, 0, "blank_vactive");
    push(0, b + 81920, S_AV, 16384, "av_after_active");
    push(0, b + 82000, S_INT, 0, "int_held");
    push(0, b + 82051, S_INT, 1, "int_ack_clears");
    push(0, b + 82052, S_INT, 1, "int_stays_clear");

    wait_until(b + 82050);
    bus0.int_ack = 1'b1;
    wait_until(b + 82051);
    bus0.int_ack = 1'b0;

    // Asynchronous reset between edges, while strobes and AV are far from reset values.
    wait_until(b + 82102);
    @(posedge clk);
    #2;
    rst0 = 1'b0;
    push_reset(0, edge_n, "reset_async");
    wait_until(b + 82106);
    rst0 = 1'b1;
    b2 = edge_n;

    push(0, b2 + 41, S_RAS, 0, "pre_freeze_ras");
    push(0, b2 + 41, S_AV, 10, "pre_freeze_av");
    push(0, b2 + 42, S_RAS, 1, "freeze_ras");
    push(0, b2 + 43, S_CPU, 0, "freeze_cpu");
    push(0, b2 + 43, S_CAS, 1, "freeze_cas");
    push(0, b2 + 43, S_LD, 1, "freeze_ld");
    push(0, b2 + 45, S_AV, 10, "freeze_av");
    push(0, b2 + 50, S_AV, 10, "freeze_av_late");
    push(0, b2 + 50, S_BL, 1, "freeze_blank");
    push(0, b2 + 51, S_CAS, 0, "resume_cas");
    push(0, b2 + 51, S_RAS, 0, "resume_ras");
    push(0, b2 + 51, S_CPU, 0, "resume_cpu");
    push(0, b2 + 52, S_CPU, 1, "resume_cpu_en");
    push(0, b2 + 52, S_LD, 0, "resume_ld");
    push(0, b2 + 53, S_AV, 11, "resume_av");
    push(0, b2 + 53, S_RAS, 1, "resume_ras_idle");

    wait_until(b2 + 41);
    bus0.enable = 1'b0;
    wait_until(b2 + 50);
    bus0.enable = 1'b1;
    wait_until(b2 + 54);
  endtask

  task automatic seq_small();
    int unsigned b;
    rst1 = 1'b0; bus1.enable = 1'b1; bus1.int_ack = 1'b0;
    push_reset(1, 2, "s_reset_hold");
    wait_until(3);
    rst1 = 1'b1;
    b = edge_n;

    push(1, b + 2,   S_CPU, 1,  "s_cpu_en");
    push(1, b + 2,   S_LD,  0,  "s_ld");
    push(1, b + 14,  S_BL,  1,  "s_blank_before");
    push(1, b + 15,  S_BL,  0,  "s_blank_start");
    push(1, b + 17,  S_HS,  1,  "s_hsync_before");
    push(1, b + 18,  S_HS,  0,  "s_hsync_start");
    push(1, b + 23,  S_HS,  0,  "s_hsync_last");
    push(1, b + 24,  S_HS,  1,  "s_hsync_end");
    push(1, b + 84,  S_AV,  19, "s_av_last_cell");
    push(1, b + 87,  S_AV,  20, "s_av_after_active");
    push(1, b + 95,  S_VS,  1,  "s_vsync_before");
    push(1, b + 95,  S_INT, 1,  "s_int_before");
    push(1, b + 96,  S_VS,  0,  "s_vsync_start");
    push(1, b + 96,  S_INT, 0,  "s_int_fall");
    push(1, b + 96,  S_BL,  0,  "s_blank_vactive");
    push(1, b + 119, S_VS,  0,  "s_vsync_last");
    push(1, b + 120, S_VS,  1,  "s_vsync_end");
    push(1, b + 143, S_AV,  20, "s_av_frame_end");
    push(1, b + 144, S_AV,  0,  "s_av_frame_clear");
    push(1, b + 147, S_AV,  1,  "s_av_next_frame");
    push(1, b + 150, S_INT, 0,  "s_int_held");
    push(1, b + 151, S_INT, 1,  "s_int_ack");
    push(1, b + 239, S_INT, 1,  "s_int_cleared");
    push(1, b + 239, S_VS,  1,  "s_vsync2_before");
    push(1, b + 240, S_VS,  0,  "s_vsync2_start");
    push(1, b + 240, S_INT, 0,  "s_int_set_wins");
    push(1, b + 241, S_INT, 0,  "s_int_stays_low");

    wait_until(b + 150);
    bus1.int_ack = 1'b1;
    wait_until(b + 151);
    bus1.int_ack = 1'b0;
    wait_until(b + 239);
    bus1.int_ack = 1'b1;
    wait_until(b + 240);
    bus1.int_ack = 1'b0;
    wait_until(b + 242);
  endtask

  initial begin
    fork
      seq_default();
      seq_small();
    join
    @(negedge clk);
    draining = 1'b1;
    @(negedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
